ex_stage: RTL and testbench

Execute stage of the 5-stage MIPS pipeline. Consumes the ID/EX register outputs, resolves operand forwarding from the MEM and WB stages, and performs ALU and branch-compare operations. It also runs an iterative signed multiply/divide unit into HI/LO. Results go into an internal EX/MEM register; a `Busy` output stalls IF/ID/ID_EX while a multiply or divide is in flight.

---
 rtl/mips_pkg.sv | 31 +++
 rtl/ex_stage_if.sv | 26 ++
 rtl/muldiv_seq.sv | 113 +++++++++++
 rtl/ex_stage.sv | 119 +++++++++++
 tb/tb_ex_stage.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS execute stage: ALU control codes,
// the mul/div sequencer state type and its default iteration count.
package mips_pkg;

   localparam int MD_CYCLES_DEF = 32;

   localparam logic [5:0] ALU_SLL  = 6'h00;
   localparam logic [5:0] ALU_SRL  = 6'h02;
   localparam logic [5:0] ALU_MFHI = 6'h10;
   localparam logic [5:0] ALU_MFLO = 6'h12;
   localparam logic [5:0] ALU_MULT = 6'h18;
   localparam logic [5:0] ALU_DIV  = 6'h1A;
   localparam logic [5:0] ALU_ADD  = 6'h20;
   localparam logic [5:0] ALU_SUB  = 6'h22;
   localparam logic [5:0] ALU_AND  = 6'h24;
   localparam logic [5:0] ALU_OR   = 6'h25;
   localparam logic [5:0] ALU_XOR  = 6'h26;
   localparam logic [5:0] ALU_NOR  = 6'h27;
   localparam logic [5:0] ALU_SLT  = 6'h2A;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_DONE = 2'd2
   } mdState_t;

   function automatic logic isMulDiv(input logic [5:0] code);
      return (code == ALU_MULT) || (code == ALU_DIV);
   endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX pipeline register bundle feeding the execute stage.
interface ex_stage_if;
   logic [31:0] RegData1In;
   logic [31:0] RegData2In;
   logic [31:0] ExtendidoIn;
   logic [4:0]  rsIn;
   logic [4:0]  rtIn;
   logic [4:0]  rdIn;
   logic [5:0]  ALUControlIn;
   logic        ALUSrcIn;
   logic        RegWriteIn;
   logic        MemtoRegIn;
   logic        MemWriteIn;
   logic        RegDstIn;
   logic        BranchIn;

   modport master (
      output RegData1In, RegData2In, ExtendidoIn, rsIn, rtIn, rdIn, ALUControlIn,
             ALUSrcIn, RegWriteIn, MemtoRegIn, MemWriteIn, RegDstIn, BranchIn
   );

   modport slave (
      input  RegData1In, RegData2In, ExtendidoIn, rsIn, rtIn, rdIn, ALUControlIn,
             ALUSrcIn, RegWriteIn, MemtoRegIn, MemWriteIn, RegDstIn, BranchIn
   );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative signed multiply/divide engine writing HI/LO; works on operand
// magnitudes and fixes signs in DONE. Only built when EX_MULDIV_EN is defined.
`ifdef EX_MULDIV_EN
module muldiv_seq
   import mips_pkg::*;
#(
   parameter int MD_CYCLES = MD_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   mdState_t    state;
   logic [6:0]  count;
   logic        divOp, aNeg, bNeg, bZero;
   logic [31:0] aHold, magOp, absA, absB;
   logic [64:0] acc, accNext;
   logic [32:0] mulSum, remShift, remDiff;
   logic [63:0] prodS;
   logic [31:0] quotS, remS, hiNext, loNext;

   assign absA = a[31] ? (32'd0 - a) : a;
   assign absB = b[31] ? (32'd0 - b) : b;
   assign busy = (state == MD_RUN) || ((state == MD_IDLE) && start);

   // One iteration: shift-add for mult, restoring shift-subtract for div
   always_comb begin
      mulSum   = acc[64:32] + (acc[0] ? {1'b0, magOp} : 33'd0);
      remShift = acc[63:31];
      remDiff  = remShift - {1'b0, magOp};
      if (divOp) begin
         if (remShift >= {1'b0, magOp}) begin
            accNext = {remDiff, acc[30:0], 1'b1};
         end else begin
            accNext = {remShift, acc[30:0], 1'b0};
         end
      end else begin
         accNext = {1'b0, mulSum, acc[31:1]};
      end
   end

   // Sign correction and divide-by-zero result applied in DONE
   always_comb begin
      prodS = (aNeg ^ bNeg) ? (64'd0 - acc[63:0]) : acc[63:0];
      quotS = (aNeg ^ bNeg) ? (32'd0 - acc[31:0]) : acc[31:0];
      remS  = aNeg ? (32'd0 - acc[63:32]) : acc[63:32];
      if (!divOp) begin
         hiNext = prodS[63:32];
         loNext = prodS[31:0];
      end else if (bZero) begin
         hiNext = aHold;
         loNext = 32'hFFFF_FFFF;
      end else begin
         hiNext = remS;
         loNext = quotS;
      end
   end

   // Sequencer state, iteration datapath and HI/LO registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= MD_IDLE;
         count <= 7'd0;
         divOp <= 1'b0;
         aNeg  <= 1'b0;
         bNeg  <= 1'b0;
         bZero <= 1'b0;
         aHold <= 32'd0;
         magOp <= 32'd0;
         acc   <= 65'd0;
         hi    <= 32'd0;
         lo    <= 32'd0;
      end else begin
         case (state)
            MD_IDLE: begin
               if (start) begin
                  divOp <= op;
                  aNeg  <= a[31];
                  bNeg  <= b[31];
                  bZero <= (b == 32'd0);
                  aHold <= a;
                  count <= 7'd0;
                  magOp <= op ? absB : absA;
                  acc   <= {33'd0, (op ? absA : absB)};
                  state <= MD_RUN;
               end
            end
            MD_RUN: begin
               acc   <= accNext;
               count <= count + 7'd1;
               if (count == 7'(MD_CYCLES - 1)) begin
                  state <= MD_DONE;
               end
            end
            MD_DONE: begin
               hi    <= hiNext;
               lo    <= loNext;
               state <= MD_IDLE;
            end
            default: state <= MD_IDLE;
         endcase
      end
   end

endmodule
`endif

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding, ALU, branch compare and EX/MEM register.
// Define EX_MULDIV_EN to build the HI/LO mul/div unit and mfhi/mflo/mult/div.
module ex_stage
   import mips_pkg::*;
#(
   parameter int MD_CYCLES = MD_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   ex_stage_if.slave   idEx,
   input  logic        MemRegWrite,
   input  logic [4:0]  MemWriteReg,
   input  logic [31:0] MemALUResult,
   input  logic        WbRegWrite,
   input  logic [4:0]  WbWriteReg,
   input  logic [31:0] WbData,
   output logic [31:0] ALUResultOut,
   output logic [31:0] WriteDataOut,
   output logic [4:0]  WriteRegOut,
   output logic        RegWriteOut,
   output logic        MemtoRegOut,
   output logic        MemWriteOut,
   output logic        BranchTakenOut,
   output logic        Busy
);

   logic [31:0] opA, fwdB, opB, aluRes;
   logic [4:0]  shamt;
   logic        mdOp;

`ifdef EX_MULDIV_EN
   logic [31:0] hiVal, loVal;

   assign mdOp = isMulDiv(idEx.ALUControlIn);

   muldiv_seq #(.MD_CYCLES(MD_CYCLES)) uMulDiv (
      .clk   (clk),
      .rst_n (rst_n),
      .start (mdOp),
      .op    (idEx.ALUControlIn == ALU_DIV),
      .a     (opA),
      .b     (fwdB),
      .busy  (Busy),
      .hi    (hiVal),
      .lo    (loVal)
   );
`else
   assign mdOp = 1'b0;
   assign Busy = 1'b0;
`endif

   // Operand forwarding: MEM beats WB, register 0 never forwards
   always_comb begin
      if (MemRegWrite && (MemWriteReg != 5'd0) && (MemWriteReg == idEx.rsIn)) begin
         opA = MemALUResult;
      end else if (WbRegWrite && (WbWriteReg != 5'd0) && (WbWriteReg == idEx.rsIn)) begin
         opA = WbData;
      end else begin
         opA = idEx.RegData1In;
      end
      if (MemRegWrite && (MemWriteReg != 5'd0) && (MemWriteReg == idEx.rtIn)) begin
         fwdB = MemALUResult;
      end else if (WbRegWrite && (WbWriteReg != 5'd0) && (WbWriteReg == idEx.rtIn)) begin
         fwdB = WbData;
      end else begin
         fwdB = idEx.RegData2In;
      end
   end

   assign opB   = idEx.ALUSrcIn ? idEx.ExtendidoIn : fwdB;
   assign shamt = idEx.ExtendidoIn[10:6];

   // ALU result select
   always_comb begin
      case (idEx.ALUControlIn)
         ALU_ADD:  aluRes = opA + opB;
         ALU_SUB:  aluRes = opA - opB;
         ALU_AND:  aluRes = opA & opB;
         ALU_OR:   aluRes = opA | opB;
         ALU_XOR:  aluRes = opA ^ opB;
         ALU_NOR:  aluRes = ~(opA | opB);
         ALU_SLT:  aluRes = {31'd0, ($signed(opA) < $signed(opB))};
         ALU_SLL:  aluRes = opB << shamt;
         ALU_SRL:  aluRes = opB >> shamt;
`ifdef EX_MULDIV_EN
         ALU_MFHI: aluRes = hiVal;
         ALU_MFLO: aluRes = loVal;
`endif
         default:  aluRes = 32'd0;
      endcase
   end

   // EX/MEM register; a stalled cycle or a mult/div retiring loads a bubble
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ALUResultOut   <= 32'd0;
         WriteDataOut   <= 32'd0;
         WriteRegOut    <= 5'd0;
         RegWriteOut    <= 1'b0;
         MemtoRegOut    <= 1'b0;
         MemWriteOut    <= 1'b0;
         BranchTakenOut <= 1'b0;
      end else if (Busy) begin
         RegWriteOut    <= 1'b0;
         MemtoRegOut    <= 1'b0;
         MemWriteOut    <= 1'b0;
         BranchTakenOut <= 1'b0;
      end else begin
         ALUResultOut   <= aluRes;
         WriteDataOut   <= fwdB;
         WriteRegOut    <= idEx.RegDstIn ? idEx.rdIn : idEx.rtIn;
         RegWriteOut    <= idEx.RegWriteIn & ~mdOp;
         MemtoRegOut    <= idEx.MemtoRegIn & ~mdOp;
         MemWriteOut    <= idEx.MemWriteIn & ~mdOp;
         BranchTakenOut <= idEx.BranchIn & (opA == opB) & ~mdOp;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized ops
// against an arithmetic reference model (HI/LO model follows EX_MULDIV_EN).
module tb_ex_stage;

`ifdef EX_MULDIV_EN
   localparam bit MD_EN = 1'b1;
`else
   localparam bit MD_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        MemRegWrite, WbRegWrite;
   logic [4:0]  MemWriteReg, WbWriteReg;
   logic [31:0] MemALUResult, WbData;
   logic [31:0] ALUResultOut, WriteDataOut;
   logic [4:0]  WriteRegOut;
   logic        RegWriteOut, MemtoRegOut, MemWriteOut, BranchTakenOut, Busy;

   ex_stage_if idex ();

   ex_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .idEx           (idex),
      .MemRegWrite    (MemRegWrite),
      .MemWriteReg    (MemWriteReg),
      .MemALUResult   (MemALUResult),
      .WbRegWrite     (WbRegWrite),
      .WbWriteReg     (WbWriteReg),
      .WbData         (WbData),
      .ALUResultOut   (ALUResultOut),
      .WriteDataOut   (WriteDataOut),
      .WriteRegOut    (WriteRegOut),
      .RegWriteOut    (RegWriteOut),
      .MemtoRegOut    (MemtoRegOut),
      .MemWriteOut    (MemWriteOut),
      .BranchTakenOut (BranchTakenOut),
      .Busy           (Busy)
   );

   int          vecCnt = 0;
   int          errCnt = 0;
   logic [31:0] mHi, mLo, lastRes;
   logic [5:0]  codeTab [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                                 6'h2A, 6'h00, 6'h02, 6'h10, 6'h12, 6'h3F};

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecCnt++;
      if (got !== exp) begin
         errCnt++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] fwdModel(input logic [4:0] spec, input logic [31:0] rf);
      if (MemRegWrite && spec != 5'd0 && MemWriteReg == spec) return MemALUResult;
      if (WbRegWrite && spec != 5'd0 && WbWriteReg == spec) return WbData;
      return rf;
   endfunction

   function automatic logic [31:0] aluModel(input logic [5:0] code, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
      case (code)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h26:   return a ^ b;
         6'h27:   return ~(a | b);
         6'h2A:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         6'h00:   return b << sh;
         6'h02:   return b >> sh;
         6'h10:   return MD_EN ? mHi : 32'd0;
         6'h12:   return MD_EN ? mLo : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   task automatic drive(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ext, input logic aluSrc);
      idex.ALUControlIn = code;
      idex.RegData1In   = a;
      idex.RegData2In   = b;
      idex.ExtendidoIn  = ext;
      idex.ALUSrcIn     = aluSrc;
      idex.rsIn = 5'd0; idex.rtIn = 5'd0; idex.rdIn = 5'd3;
      idex.RegDstIn = 1'b1; idex.RegWriteIn = 1'b1;
      idex.MemtoRegIn = 1'b0; idex.MemWriteIn = 1'b0; idex.BranchIn = 1'b0;
      MemRegWrite = 1'b0; MemWriteReg = 5'd0; MemALUResult = 32'd0;
      WbRegWrite = 1'b0; WbWriteReg = 5'd0; WbData = 32'd0;
   endtask

   // Predict EX/MEM contents from the presented inputs, clock once, compare
   task automatic stepCheck(input string tag);
      logic [31:0] fA, fB, oB, eRes;
      logic [4:0]  eReg;
      logic        md, eBr;
      fA   = fwdModel(idex.rsIn, idex.RegData1In);
      fB   = fwdModel(idex.rtIn, idex.RegData2In);
      oB   = idex.ALUSrcIn ? idex.ExtendidoIn : fB;
      md   = MD_EN && (idex.ALUControlIn == 6'h18 || idex.ALUControlIn == 6'h1A);
      eRes = aluModel(idex.ALUControlIn, fA, oB, idex.ExtendidoIn[10:6]);
      eReg = idex.RegDstIn ? idex.rdIn : idex.rtIn;
      eBr  = idex.BranchIn && (fA == oB) && !md;
      @(posedge clk); #1;
      checkVal({tag, ".res"},   ALUResultOut, eRes);
      checkVal({tag, ".wdata"}, WriteDataOut, fB);
      checkVal({tag, ".wreg"},  {27'd0, WriteRegOut}, {27'd0, eReg});
      checkVal({tag, ".rw"},    {31'd0, RegWriteOut}, {31'd0, idex.RegWriteIn && !md});
      checkVal({tag, ".m2r"},   {31'd0, MemtoRegOut}, {31'd0, idex.MemtoRegIn && !md});
      checkVal({tag, ".mw"},    {31'd0, MemWriteOut}, {31'd0, idex.MemWriteIn && !md});
      checkVal({tag, ".br"},    {31'd0, BranchTakenOut}, {31'd0, eBr});
      lastRes = eRes;
   endtask

   task automatic runMulDiv(input string tag, input logic isDiv, input logic [31:0] a, input logic [31:0] b);
      int          busyCnt;
      int          sa, sb;
      longint      p;
      logic [63:0] pv;
      drive(isDiv ? 6'h1A : 6'h18, a, b, 32'd0, 1'b0);
      #1;
      busyCnt = 0;
      while (Busy && busyCnt < 40) begin
         busyCnt++;
         if (busyCnt == 5) begin
            checkVal({tag, ".bubble.rw"}, {31'd0, RegWriteOut}, 32'd0);
            checkVal({tag, ".bubble.hold"}, ALUResultOut, lastRes);
         end
         @(posedge clk); #2;
      end
      checkVal({tag, ".busycycles"}, busyCnt, MD_EN ? 32'd33 : 32'd0);
      if (MD_EN) begin
         sa = a;
         sb = b;
         if (!isDiv) begin
            p = longint'(sa) * longint'(sb);
            pv = p;
            mHi = pv[63:32];
            mLo = pv[31:0];
         end else if (b == 32'd0) begin
            mHi = a;
            mLo = 32'hFFFF_FFFF;
         end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            mHi = 32'd0;
            mLo = 32'h8000_0000;
         end else begin
            mLo = sa / sb;
            mHi = sa % sb;
         end
      end
      stepCheck({tag, ".retire"});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      drive(6'h3F, 32'd0, 32'd0, 32'd0, 1'b0);
      mHi = 32'd0; mLo = 32'd0; lastRes = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      checkVal("reset.res",  ALUResultOut, 32'd0);
      checkVal("reset.wreg", {27'd0, WriteRegOut}, 32'd0);
      checkVal("reset.rw",   {31'd0, RegWriteOut}, 32'd0);
      checkVal("reset.busy", {31'd0, Busy}, 32'd0);
      rst_n = 1'b1;

      drive(6'h20, 32'd5, 32'd7, 32'd0, 1'b0); stepCheck("add");
      checkVal("add.12", ALUResultOut, 32'd12);
      drive(6'h22, 32'd3, 32'd5, 32'd0, 1'b0); stepCheck("sub");
      checkVal("sub.neg2", ALUResultOut, 32'hFFFF_FFFE);
      drive(6'h2A, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0); stepCheck("slt");
      checkVal("slt.1", ALUResultOut, 32'd1);
      drive(6'h00, 32'd0, 32'h0000_0013, 32'h0000_0100, 1'b0); stepCheck("sll4");

      drive(6'h20, 32'h11, 32'd0, 32'd0, 1'b0);
      idex.rsIn = 5'd8; MemRegWrite = 1'b1; MemWriteReg = 5'd8; MemALUResult = 32'hAA;
      WbRegWrite = 1'b1; WbWriteReg = 5'd8; WbData = 32'hBB;
      stepCheck("fwd.mem");
      checkVal("fwd.mem.AA", ALUResultOut, 32'hAA);
      MemRegWrite = 1'b0; stepCheck("fwd.wb");
      checkVal("fwd.wb.BB", ALUResultOut, 32'hBB);
      MemRegWrite = 1'b1; idex.rsIn = 5'd0; MemWriteReg = 5'd0; WbWriteReg = 5'd0;
      stepCheck("fwd.r0");
      checkVal("fwd.r0.rf", ALUResultOut, 32'h11);

      drive(6'h22, 32'h1234, 32'h1234, 32'd0, 1'b0); idex.BranchIn = 1'b1; stepCheck("beq.eq");
      checkVal("beq.taken", {31'd0, BranchTakenOut}, 32'd1);
      idex.RegData2In = 32'h1235; stepCheck("beq.ne");
      checkVal("beq.nottaken", {31'd0, BranchTakenOut}, 32'd0);

      runMulDiv("mult", 1'b0, 32'hFFFF_FFFD, 32'd7);
      drive(6'h12, 32'd0, 32'd0, 32'd0, 1'b0); stepCheck("mflo");
      checkVal("mult.lo", ALUResultOut, MD_EN ? 32'hFFFF_FFEB : 32'd0);
      drive(6'h10, 32'd0, 32'd0, 32'd0, 1'b0); stepCheck("mfhi");
      checkVal("mult.hi", ALUResultOut, MD_EN ? 32'hFFFF_FFFF : 32'd0);
      runMulDiv("div", 1'b1, 32'hFFFF_FFF9, 32'd2);
      drive(6'h12, 32'd0, 32'd0, 32'd0, 1'b0); stepCheck("div.mflo");
      checkVal("div.lo", ALUResultOut, MD_EN ? 32'hFFFF_FFFD : 32'd0);
      runMulDiv("div0", 1'b1, 32'd9, 32'd0);
      drive(6'h10, 32'd0, 32'd0, 32'd0, 1'b0); stepCheck("div0.mfhi");
      checkVal("div0.hi", ALUResultOut, MD_EN ? 32'd9 : 32'd0);
      runMulDiv("divmin", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      drive(6'h12, 32'd0, 32'd0, 32'd0, 1'b0); stepCheck("divmin.mflo");

      for (int i = 0; i < 200; i++) begin
         int k;
         k = $urandom_range(0, 11);
         drive(codeTab[k], $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
         if (k == 11) begin
            idex.ALUControlIn = 6'($urandom);
            if (idex.ALUControlIn == 6'h18 || idex.ALUControlIn == 6'h1A) idex.ALUControlIn = 6'h3F;
         end
         if ($urandom_range(0, 3) == 0) begin
            idex.RegData2In = idex.RegData1In;
            idex.ALUSrcIn = 1'b0;
         end
         idex.rsIn = 5'($urandom_range(0, 3));
         idex.rtIn = 5'($urandom_range(0, 3));
         idex.rdIn = 5'($urandom);
         idex.RegDstIn   = 1'($urandom_range(0, 1));
         idex.RegWriteIn = 1'($urandom_range(0, 1));
         idex.MemtoRegIn = 1'($urandom_range(0, 1));
         idex.MemWriteIn = 1'($urandom_range(0, 1));
         idex.BranchIn   = 1'($urandom_range(0, 1));
         MemRegWrite = 1'($urandom_range(0, 1));
         MemWriteReg = 5'($urandom_range(0, 3));
         MemALUResult = $urandom;
         WbRegWrite = 1'($urandom_range(0, 1));
         WbWriteReg = 5'($urandom_range(0, 3));
         WbData = $urandom;
         stepCheck("rnd");
      end

      for (int i = 0; i < 6; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = (i == 5) ? 32'd0 : ((i[0]) ? 32'($urandom_range(1, 500)) : $urandom);
         runMulDiv("rndmd", 1'(i % 2), ra, rb);
         drive(6'h12, 32'd0, 32'd0, 32'd0, 1'b0); stepCheck("rndmd.mflo");
         drive(6'h10, 32'd0, 32'd0, 32'd0, 1'b0); stepCheck("rndmd.mfhi");
      end

      drive(6'h18, 32'hFFFF_FFFD, 32'd7, 32'd0, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      drive(6'h3F, 32'd0, 32'd0, 32'd0, 1'b0);
      idex.RegWriteIn = 1'b0;
      @(posedge clk); #1;
      checkVal("midrst.busy", {31'd0, Busy}, 32'd0);
      checkVal("midrst.res",  ALUResultOut, 32'd0);
      checkVal("midrst.wdata", WriteDataOut, 32'd0);
      checkVal("midrst.wreg", {27'd0, WriteRegOut}, 32'd0);
      checkVal("midrst.rw",   {31'd0, RegWriteOut}, 32'd0);
      mHi = 32'd0; mLo = 32'd0;
      rst_n = 1'b1;
      drive(6'h10, 32'd0, 32'd0, 32'd0, 1'b0); stepCheck("midrst.mfhi");
      checkVal("midrst.hi0", ALUResultOut, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
      $finish;
   end

endmodule
